// File: rtl/id_stage_pipe.sv
// MIPS decode stage: decoder, bypassed register file, immediate extension,
// branch resolution, hazard stall and a registered ID/EX pipeline register.
module id_stage_pipe #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int BR_SHIFT    = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [31:0]            instruction,
    input  logic [DATA_W-1:0]      pc_in,
    input  logic                   flush,
    input  logic                   wb_en,
    input  logic [REG_AW-1:0]      wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   stall,
    output logic                   branch_taken,
    output logic [DATA_W-1:0]      branch_target,
    output logic                   ex_valid,
    output logic                   ex_wr_reg,
    output logic                   ex_is_lw,
    output logic                   ex_mem_write,
    output logic                   ex_mem_to_reg,
    output logic                   ex_alu_src_b,
    output logic [2:0]             ex_alu_op,
    output logic [DATA_W-1:0]      ex_rs_data,
    output logic [DATA_W-1:0]      ex_rt_data,
    output logic [DATA_W-1:0]      ex_imm,
    output logic [REG_AW-1:0]      ex_rs,
    output logic [REG_AW-1:0]      ex_rt,
    output logic [REG_AW-1:0]      ex_targ,
    output logic [STALL_CNT_W-1:0] stall_count
);
    localparam int NREG = 1 << REG_AW;

    typedef enum logic [5:0] {
        OP_ADD  = 6'b000000,
        OP_SUB  = 6'b000001,
        OP_OR   = 6'b010000,
        OP_AND  = 6'b010001,
        OP_ADDI = 6'b000010,
        OP_ORI  = 6'b010010,
        OP_LW   = 6'b100111,
        OP_SW   = 6'b100110,
        OP_BEQ  = 6'b110000,
        OP_BNE  = 6'b110001,
        OP_B    = 6'b110010
    } op_e;

    typedef struct packed {
        logic              valid;
        logic              wr_reg;
        logic              is_lw;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src_b;
        logic [2:0]        alu_op;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] targ;
    } idex_t;

    logic [5:0]        op;
    logic [REG_AW-1:0] rs_a, rt_a, rd_a;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] sext_imm, zext_imm, rs_data, rt_data;

    assign op    = instruction[31:26];
    assign rs_a  = instruction[25:21];
    assign rt_a  = instruction[20:16];
    assign rd_a  = instruction[15:11];
    assign imm16 = instruction[15:0];

    assign sext_imm = {{(DATA_W-16){imm16[15]}}, imm16};
    assign zext_imm = {{(DATA_W-16){1'b0}}, imm16};

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_addr != '0) regs_d[wb_addr] = wb_data;
    end

    // Write-first: a same-cycle write-back is visible to the reading instruction.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_a != '0) rs_data = (wb_en && wb_addr == rs_a) ? wb_data : regs_q[rs_a];
        if (rt_a != '0) rt_data = (wb_en && wb_addr == rt_a) ? wb_data : regs_q[rt_a];
    end

    idex_t dec;
    logic  use_rs, use_rt, is_beq, is_bne, is_b, zext;

    always_comb begin
        dec     = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_b    = 1'b0;
        zext    = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND: begin
                dec.wr_reg = 1'b1;
                dec.targ   = rd_a;
                use_rs     = 1'b1;
                use_rt     = 1'b1;
                dec.alu_op = (op == OP_ADD) ? 3'd0 : (op == OP_SUB) ? 3'd1 :
                             (op == OP_OR)  ? 3'd2 : 3'd3;
            end
            OP_ADDI: begin
                dec.wr_reg    = 1'b1;
                dec.targ      = rt_a;
                dec.alu_src_b = 1'b1;
                use_rs        = 1'b1;
            end
            OP_ORI: begin
                dec.alu_op    = 3'd2;
                dec.wr_reg    = 1'b1;
                dec.targ      = rt_a;
                dec.alu_src_b = 1'b1;
                use_rs        = 1'b1;
                zext          = 1'b1;
            end
            OP_LW: begin
                dec.wr_reg     = 1'b1;
                dec.targ       = rt_a;
                dec.is_lw      = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src_b  = 1'b1;
                use_rs         = 1'b1;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src_b = 1'b1;
                use_rs        = 1'b1;
                use_rt        = 1'b1;
            end
            OP_BEQ: begin
                is_beq = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_BNE: begin
                is_bne = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_B:    is_b = 1'b1;
            default: ;
        endcase
        dec.valid   = 1'b1;
        dec.rs_data = rs_data;
        dec.rt_data = rt_data;
        dec.imm     = zext ? zext_imm : sext_imm;
        dec.rs      = rs_a;
        dec.rt      = rt_a;
    end

    idex_t ex_q, ex_d;
    logic  hz;

    assign hz = in_valid & ex_q.valid & ex_q.wr_reg & (ex_q.targ != '0) &
                ((use_rs & (ex_q.targ == rs_a)) | (use_rt & (ex_q.targ == rt_a)));

    // Branches resolve in ID, so they must also wait out an ALU producer.
    assign stall         = hz & (ex_q.is_lw | is_beq | is_bne) & ~flush;
    assign branch_taken  = in_valid & ~stall & ~flush &
                           (is_b | (is_beq & (rs_data == rt_data)) | (is_bne & (rs_data != rt_data)));
    assign branch_target = pc_in + (sext_imm << BR_SHIFT);

    always_comb begin
        ex_d = dec;
        if (!in_valid || stall || flush) ex_d = '0;
    end

    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            ex_q   <= ex_d;
            cnt_q  <= cnt_d;
            regs_q <= regs_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_wr_reg     = ex_q.wr_reg;
    assign ex_is_lw      = ex_q.is_lw;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_alu_src_b  = ex_q.alu_src_b;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_rs_data    = ex_q.rs_data;
    assign ex_rt_data    = ex_q.rt_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_targ       = ex_q.targ;
    assign stall_count   = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a behavioural model pushes expected ID/EX
// entries into a queue which are popped and compared one cycle later.
module tb_id_stage_pipe;
    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0;
    logic [31:0] instruction = '0, pc_in = '0, wb_data = '0;
    logic [4:0]  wb_addr = '0;

    logic        stall, branch_taken, ex_valid, ex_wr_reg, ex_is_lw, ex_mem_write, ex_mem_to_reg, ex_alu_src_b;
    logic [31:0] branch_target, ex_rs_data, ex_rt_data, ex_imm;
    logic [2:0]  ex_alu_op;
    logic [4:0]  ex_rs, ex_rt, ex_targ;
    logic [15:0] stall_count;

    logic        s_stall, s_bt, s_v, s_wr, s_lw, s_mw, s_m2r, s_asb;
    logic [31:0] s_tgt, s_rsd, s_rtd, s_imm;
    logic [2:0]  s_alu;
    logic [4:0]  s_rs, s_rt, s_targ;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction), .pc_in(pc_in),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .ex_valid(ex_valid),
        .ex_wr_reg(ex_wr_reg), .ex_is_lw(ex_is_lw), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src_b(ex_alu_src_b), .ex_alu_op(ex_alu_op),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_targ(ex_targ), .stall_count(stall_count)
    );

    id_stage_pipe #(.STALL_CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction), .pc_in(pc_in),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(s_stall),
        .branch_taken(s_bt), .branch_target(s_tgt), .ex_valid(s_v), .ex_wr_reg(s_wr),
        .ex_is_lw(s_lw), .ex_mem_write(s_mw), .ex_mem_to_reg(s_m2r), .ex_alu_src_b(s_asb),
        .ex_alu_op(s_alu), .ex_rs_data(s_rsd), .ex_rt_data(s_rtd), .ex_imm(s_imm), .ex_rs(s_rs),
        .ex_rt(s_rt), .ex_targ(s_targ), .stall_count(s_cnt)
    );

    typedef struct packed {
        logic        vld, wr, lw, mw, m2r, asb, cmp_imm;
        logic [2:0]  alu;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  rs, rt, targ;
    } exp_t;

    exp_t        sb[$];
    int          n_err = 0, n_chk = 0;
    logic [31:0] m_regs [32];
    logic        m_vld, m_wr, m_lw;
    logic [4:0]  m_targ;
    int          m_cnt, m_cnt_s;
    logic        st_o, bt_o;
    logic [31:0] tg_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_vld = 0; m_wr = 0; m_lw = 0; m_targ = '0; m_cnt = 0; m_cnt_s = 0;
        sb.delete();
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs, rt, rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // One ID cycle: drive, check combinational outputs, push expectation,
    // clock, then pop and compare the ID/EX register.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t        e, g;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] im;
        logic        ur, ut, sx, zx, beq, bne, bb, hz, st, bt;
        logic [31:0] rsd, rtd, tgt;
        in_valid = iv; instruction = ins; pc_in = pc; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; im = ins[15:0];
        e = '0; ur = 0; ut = 0; sx = 0; zx = 0; beq = 0; bne = 0; bb = 0;
        case (op)
            6'b000000: begin e.wr = 1; e.targ = rd; ur = 1; ut = 1; e.alu = 3'd0; end
            6'b000001: begin e.wr = 1; e.targ = rd; ur = 1; ut = 1; e.alu = 3'd1; end
            6'b010000: begin e.wr = 1; e.targ = rd; ur = 1; ut = 1; e.alu = 3'd2; end
            6'b010001: begin e.wr = 1; e.targ = rd; ur = 1; ut = 1; e.alu = 3'd3; end
            6'b000010: begin e.wr = 1; e.targ = rt; ur = 1; sx = 1; e.asb = 1; end
            6'b010010: begin e.wr = 1; e.targ = rt; ur = 1; zx = 1; e.asb = 1; e.alu = 3'd2; end
            6'b100111: begin e.wr = 1; e.targ = rt; ur = 1; sx = 1; e.asb = 1; e.lw = 1; e.m2r = 1; end
            6'b100110: begin ur = 1; ut = 1; sx = 1; e.asb = 1; e.mw = 1; end
            6'b110000: begin ur = 1; ut = 1; sx = 1; beq = 1; end
            6'b110001: begin ur = 1; ut = 1; sx = 1; bne = 1; end
            6'b110010: begin sx = 1; bb = 1; end
            default: ;
        endcase
        rsd = (rs == 0) ? 32'd0 : (we && wa == rs) ? wd : m_regs[rs];
        rtd = (rt == 0) ? 32'd0 : (we && wa == rt) ? wd : m_regs[rt];
        hz  = iv & m_vld & m_wr & (m_targ != 0) & ((ur & (m_targ == rs)) | (ut & (m_targ == rt)));
        st  = hz & (m_lw | beq | bne) & ~fl;
        bt  = iv & ~st & ~fl & (bb | (beq & (rsd == rtd)) | (bne & (rsd != rtd)));
        tgt = pc + ({{16{im[15]}}, im} << 2);
        e.vld = 1; e.rsd = rsd; e.rtd = rtd; e.rs = rs; e.rt = rt; e.cmp_imm = sx | zx;
        e.imm = zx ? {16'd0, im} : {{16{im[15]}}, im};
        if (!iv || st || fl) e = '0;
        sb.push_back(e);
        #3;
        st_o = stall; bt_o = branch_taken; tg_o = branch_target;
        chk("stall", {31'd0, stall}, {31'd0, st});
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, bt});
        if (bt) chk("branch_target", branch_target, tgt);
        @(posedge clk); #1;
        if (we && wa != 0) m_regs[wa] = wd;
        m_vld = e.vld; m_wr = e.wr; m_lw = e.lw; m_targ = e.targ;
        if (st) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
        end
        g = sb.pop_front();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, g.vld});
        chk("ex_ctrl", {26'd0, ex_wr_reg, ex_is_lw, ex_mem_write, ex_mem_to_reg, ex_alu_src_b, s_v},
                       {26'd0, g.wr, g.lw, g.mw, g.m2r, g.asb, g.vld});
        chk("ex_alu_op", {29'd0, ex_alu_op}, {29'd0, g.alu});
        if (g.vld) begin
            chk("ex_rs_data", ex_rs_data, g.rsd);
            chk("ex_rt_data", ex_rt_data, g.rtd);
            chk("ex_idx", {22'd0, ex_rs, ex_rt}, {22'd0, g.rs, g.rt});
            if (g.wr) chk("ex_targ", {27'd0, ex_targ}, {27'd0, g.targ});
            if (g.cmp_imm) chk("ex_imm", ex_imm, g.imm);
        end
        chk("stall_count", {16'd0, stall_count}, m_cnt);
        chk("stall_count_sat", {30'd0, s_cnt}, m_cnt_s);
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_data", ex_rs_data | ex_rt_data | ex_imm, 32'd0);
        chk("rst_count", {16'd0, stall_count}, 32'd0);
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // write-first bypass
        step(1, r_ins(6'b000000, 5'd3, 5'd0, 5'd1), 32'h4, 0, 1, 5'd3, 32'h1234);
        chk("byp_rs_data", ex_rs_data, 32'h1234);
        chk("byp_targ", {27'd0, ex_targ}, 32'd1);
        chk("byp_alu", {29'd0, ex_alu_op}, 32'd0);

        // preload registers with IF empty
        step(0, '0, '0, 0, 1, 5'd5, 32'hDEAD_0005);
        step(0, '0, '0, 0, 1, 5'd6, 32'h8000_0001);

        // other opcodes, including a reserved one
        step(1, i_ins(6'b010010, 5'd3, 5'd7, 16'h8001), 32'h8, 0, 0, 0, 0);
        step(1, i_ins(6'b100110, 5'd5, 5'd7, 16'hFFFC), 32'hC, 0, 0, 0, 0);
        step(1, r_ins(6'b000001, 5'd5, 5'd6, 5'd8), 32'h10, 0, 0, 0, 0);
        step(1, r_ins(6'b010000, 5'd8, 5'd3, 5'd9), 32'h14, 0, 0, 0, 0);
        step(1, r_ins(6'b010001, 5'd6, 5'd5, 5'd10), 32'h18, 0, 0, 0, 0);
        step(1, 32'hFC00_0000 | r_ins(6'b0, 5'd5, 5'd6, 5'd11), 32'h1C, 0, 0, 0, 0);

        // load-use: one stall, then the ADD issues
        step(1, i_ins(6'b100111, 5'd1, 5'd2, 16'd4), 32'h20, 0, 0, 0, 0);
        step(1, r_ins(6'b000000, 5'd2, 5'd2, 5'd4), 32'h24, 0, 0, 0, 0);
        chk("lu_stall", {31'd0, st_o}, 32'd1);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        step(1, r_ins(6'b000000, 5'd2, 5'd2, 5'd4), 32'h24, 0, 0, 0, 0);
        chk("lu_count", {16'd0, stall_count}, 32'd1);
        step(1, i_ins(6'b100111, 5'd1, 5'd0, 16'd4), 32'h28, 0, 0, 0, 0);
        step(1, r_ins(6'b000000, 5'd0, 5'd0, 5'd4), 32'h2C, 0, 0, 0, 0);
        chk("lu_r0_nostall", {31'd0, st_o}, 32'd0);

        // BEQ behind an ALU producer, resolved with the write-back bypass
        step(1, i_ins(6'b000010, 5'd0, 5'd1, 16'd5), 32'hFC, 0, 0, 0, 0);
        step(1, i_ins(6'b110000, 5'd1, 5'd1, 16'hFFFE), 32'h100, 0, 0, 0, 0);
        chk("beq_stall", {31'd0, st_o}, 32'd1);
        step(1, i_ins(6'b110000, 5'd1, 5'd1, 16'hFFFE), 32'h100, 0, 1, 5'd1, 32'd5);
        chk("beq_taken", {31'd0, bt_o}, 32'd1);
        chk("beq_target", tg_o, 32'h0000_00F8);
        step(1, i_ins(6'b110001, 5'd1, 5'd1, 16'h0010), 32'h104, 0, 0, 0, 0);
        chk("bne_eq_not_taken", {31'd0, bt_o}, 32'd0);

        // flush beats a live hazard; unconditional branch target wraps
        step(1, i_ins(6'b100111, 5'd0, 5'd2, 16'd0), 32'h200, 0, 0, 0, 0);
        step(1, i_ins(6'b110000, 5'd2, 5'd2, 16'd0), 32'h204, 1, 0, 0, 0);
        chk("flush_stall", {31'd0, st_o}, 32'd0);
        chk("flush_bt", {31'd0, bt_o}, 32'd0);
        step(1, i_ins(6'b110010, 5'd0, 5'd0, 16'h7FFF), 32'hFFFF_0000, 0, 0, 0, 0);
        chk("b_wrap_target", tg_o, 32'h0000_FFFC);

        // repeated load-use hazards saturate the narrow counter
        for (int k = 0; k < 5; k++) begin
            step(1, i_ins(6'b100111, 5'd0, 5'd2, 16'd8), 32'h300, 0, 0, 0, 0);
            step(1, r_ins(6'b000000, 5'd2, 5'd3, 5'd4), 32'h304, 0, 0, 0, 0);
            step(1, r_ins(6'b000000, 5'd2, 5'd3, 5'd4), 32'h304, 0, 0, 0, 0);
        end
        chk("sat_count", {30'd0, s_cnt}, 32'd3);
        chk("wide_count", {16'd0, stall_count}, 32'd7);

        // asynchronous reset with a live ID/EX entry
        step(1, r_ins(6'b000000, 5'd5, 5'd6, 5'd12), 32'h400, 0, 0, 0, 0);
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mid_rst_ctrl", {24'd0, ex_wr_reg, ex_is_lw, ex_mem_write, ex_mem_to_reg, ex_alu_src_b, ex_alu_op},
            32'd0);
        chk("mid_rst_count", {14'd0, s_cnt, stall_count}, 32'd0);
        #1 reset = 1'b0;
        model_reset();
        step(1, r_ins(6'b000000, 5'd5, 5'd0, 5'd6), 32'h404, 0, 0, 0, 0);
        chk("r5_after_rst", ex_rs_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
